// File: rtl/divmod_lcd_pkg.sv
// Shared definitions for the quotient/remainder LCD writer.
//   - main FSM and byte-sequencer state encodings
//   - HD44780 command bytes used during init and addressing
//   - fraction-to-ASCII table: quotient[3:0]*625 as four decimal digits
//   - divide-by-zero sentinel pair and its banner text
//   - frame_char(): the ASCII byte at a given column of the 16-char frame
package divmod_lcd_pkg;

  typedef enum logic [2:0] {PWRUP, INIT, IDLE, ADDR, TEXT, DONE} main_state_e;
  typedef enum logic [1:0] {W_IDLE, W_SETUP, W_PULSE, W_WAIT} wr_phase_e;

  localparam logic [7:0] CMD_FUNC_SET   = 8'h38;
  localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;
  localparam logic [7:0] CMD_ADDR_LINE0 = 8'h80;

  // A valid 4.4 division never yields this pair, so it flags divide-by-zero.
  localparam logic [7:0] DBZ_QUOT = 8'hFF;
  localparam logic [3:0] DBZ_REM  = 4'hF;

  localparam logic [127:0] DBZ_TEXT = "DIV BY ZERO     ";

  localparam logic [31:0] FRAC_ASCII [16] = '{
    "0000", "0625", "1250", "1875", "2500", "3125", "3750", "4375",
    "5000", "5625", "6250", "6875", "7500", "8125", "8750", "9375"
  };

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_CLEAR;
      default: return CMD_ENTRY_MODE;
    endcase
  endfunction

  // 0..15 as two ASCII decimal digits.
  function automatic logic [7:0] dec_tens(input logic [3:0] v);
    return (v >= 4'd10) ? 8'h31 : 8'h30;
  endfunction

  function automatic logic [7:0] dec_ones(input logic [3:0] v);
    logic [3:0] d;
    d = (v >= 4'd10) ? (v - 4'd10) : v;
    return 8'h30 + {4'h0, d};
  endfunction

  // Layout: "Q=II.FFFF R=RR  "
  function automatic logic [7:0] frame_char(input logic [7:0] q,
                                            input logic [3:0] r,
                                            input logic [3:0] idx);
    logic [31:0]  frac;
    logic [127:0] dbz;
    logic [7:0]   c;
    frac = FRAC_ASCII[q[3:0]];
    dbz  = DBZ_TEXT;
    if (q == DBZ_QUOT && r == DBZ_REM) begin
      c = dbz[{4'd15 - idx, 3'b000} +: 8];
    end else begin
      case (idx)
        4'd0:    c = 8'h51;            // 'Q'
        4'd1:    c = 8'h3D;            // '='
        4'd2:    c = dec_tens(q[7:4]);
        4'd3:    c = dec_ones(q[7:4]);
        4'd4:    c = 8'h2E;            // '.'
        4'd5:    c = frac[31:24];
        4'd6:    c = frac[23:16];
        4'd7:    c = frac[15:8];
        4'd8:    c = frac[7:0];
        4'd10:   c = 8'h52;            // 'R'
        4'd11:   c = 8'h3D;            // '='
        4'd12:   c = dec_tens(r);
        4'd13:   c = dec_ones(r);
        default: c = 8'h20;            // ' '
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// One HD44780 byte transfer: SETUP (1 clk, e=0), PULSE (E_PULSE_CYC clks,
// e=1), WAIT (CLR_WAIT_CYC when long_wait_i, else CMD_WAIT_CYC clks, e=0).
// data/rs are latched on go and held until the next go.
// Handshake: go_i is accepted when the sequencer is idle or in the cycle
// fin_o is high (last WAIT cycle), so back-to-back bytes have no gap cycle.
// busy_o is high whenever a byte is in flight.
// Ports: clk, rst, go_i, data_i, rs_i, long_wait_i -> busy_o, fin_o,
//        lcd_e_o, lcd_rs_o, lcd_data_o, phase_o (debug).
module lcd_byte_writer
  import divmod_lcd_pkg::*;
#(
  parameter int E_PULSE_CYC  = 25,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 100000,
  parameter int CNT_W        = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go_i,
  input  logic [7:0] data_i,
  input  logic       rs_i,
  input  logic       long_wait_i,
  output logic       busy_o,
  output logic       fin_o,
  output logic       lcd_e_o,
  output logic       lcd_rs_o,
  output logic [7:0] lcd_data_o,
  output logic [1:0] phase_o
);

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(E_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_WAIT_CYC - 1);

  wr_phase_e        phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             long_q, long_d;
  logic             accept;
  logic [CNT_W-1:0] wait_last;

  always_comb begin
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    rs_d      = rs_q;
    long_d    = long_q;
    fin_o     = 1'b0;
    accept    = 1'b0;
    wait_last = long_q ? CLR_LAST : CMD_LAST;
    case (phase_q)
      W_IDLE:  accept = go_i;
      W_SETUP: begin
        phase_d = W_PULSE;
        cnt_d   = '0;
      end
      W_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          phase_d = W_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      W_WAIT: begin
        if (cnt_q == wait_last) begin
          fin_o   = 1'b1;
          phase_d = W_IDLE;
          cnt_d   = '0;
          accept  = go_i;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: phase_d = W_IDLE;
    endcase
    if (accept) begin
      phase_d = W_SETUP;
      data_d  = data_i;
      rs_d    = rs_i;
      long_d  = long_wait_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= W_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      rs_q    <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      long_q  <= long_d;
    end
  end

  // e decodes straight from the phase register, so reset drops it at once.
  assign lcd_e_o    = (phase_q == W_PULSE);
  assign lcd_rs_o   = rs_q;
  assign lcd_data_o = data_q;
  assign busy_o     = (phase_q != W_IDLE);
  assign phase_o    = phase_q;

endmodule

// File: rtl/quot_lcd_writer.sv
// Shows a 4.4 fixed-point quotient and a 4-bit remainder on an HD44780 LCD
// (8-bit bus, write-only). After reset: power-up delay, init commands,
// then IDLE. A start in IDLE captures the inputs and writes address 0x80
// plus a 16-character frame, then pulses done.
// Ports: clk, rst (async, active high), quotient[7:0], remainder[3:0],
//        start -> ready, done, lcd_rs, lcd_rw, lcd_e, lcd_data[7:0],
//        dbg_state[2:0] (main FSM), dbg_phase[1:0] (byte sequencer).
module quot_lcd_writer
  import divmod_lcd_pkg::*;
#(
  parameter int E_PULSE_CYC    = 25,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLR_WAIT_CYC   = 100000,
  parameter int PWRUP_WAIT_CYC = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] quotient,
  input  logic [3:0] remainder,
  input  logic       start,
  output logic       ready,
  output logic       done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic [2:0] dbg_state,
  output logic [1:0] dbg_phase
);

  // One counter width covers every delay in the design without wrapping.
  localparam int MAX_A    = (PWRUP_WAIT_CYC > CLR_WAIT_CYC) ? PWRUP_WAIT_CYC : CLR_WAIT_CYC;
  localparam int MAX_B    = (CMD_WAIT_CYC > E_PULSE_CYC) ? CMD_WAIT_CYC : E_PULSE_CYC;
  localparam int MAX_WAIT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_WAIT_CYC - 1);

  main_state_e      state_q, state_d;
  logic [CNT_W-1:0] pw_cnt_q, pw_cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       quot_q, quot_d;
  logic [3:0]       rem_q, rem_d;

  logic       wr_go, wr_rs, wr_long, wr_busy, wr_fin;
  logic [7:0] wr_data;

  lcd_byte_writer #(
    .E_PULSE_CYC (E_PULSE_CYC),
    .CMD_WAIT_CYC(CMD_WAIT_CYC),
    .CLR_WAIT_CYC(CLR_WAIT_CYC),
    .CNT_W       (CNT_W)
  ) u_writer (
    .clk        (clk),
    .rst        (rst),
    .go_i       (wr_go),
    .data_i     (wr_data),
    .rs_i       (wr_rs),
    .long_wait_i(wr_long),
    .busy_o     (wr_busy),
    .fin_o      (wr_fin),
    .lcd_e_o    (lcd_e),
    .lcd_rs_o   (lcd_rs),
    .lcd_data_o (lcd_data),
    .phase_o    (dbg_phase)
  );

  assign ready = (state_q == IDLE) && !wr_busy;

  // Each next byte is issued in the cycle the current one finishes, so
  // bytes run back to back and frame timing is exactly 17 byte slots.
  always_comb begin
    state_d  = state_q;
    pw_cnt_d = pw_cnt_q;
    idx_d    = idx_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    wr_go    = 1'b0;
    wr_data  = 8'h00;
    wr_rs    = 1'b0;
    wr_long  = 1'b0;
    done     = 1'b0;
    case (state_q)
      PWRUP: begin
        if (pw_cnt_q == PWRUP_LAST) begin
          pw_cnt_d = '0;
          idx_d    = 4'd0;
          wr_go    = 1'b1;
          wr_data  = init_cmd(2'd0);
          state_d  = INIT;
        end else begin
          pw_cnt_d = pw_cnt_q + CNT_W'(1);
        end
      end
      INIT: begin
        if (wr_fin) begin
          if (idx_q == 4'd3) begin
            idx_d   = 4'd0;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            wr_go   = 1'b1;
            wr_data = init_cmd(idx_q[1:0] + 2'd1);
            wr_long = (init_cmd(idx_q[1:0] + 2'd1) == CMD_CLEAR);
          end
        end
      end
      IDLE: begin
        if (start && ready) begin
          quot_d  = quotient;
          rem_d   = remainder;
          wr_go   = 1'b1;
          wr_data = CMD_ADDR_LINE0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (wr_fin) begin
          idx_d   = 4'd0;
          wr_go   = 1'b1;
          wr_rs   = 1'b1;
          wr_data = frame_char(quot_q, rem_q, 4'd0);
          state_d = TEXT;
        end
      end
      TEXT: begin
        if (wr_fin) begin
          if (idx_q == 4'd15) begin
            idx_d   = 4'd0;
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            wr_go   = 1'b1;
            wr_rs   = 1'b1;
            wr_data = frame_char(quot_q, rem_q, idx_q + 4'd1);
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = PWRUP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= PWRUP;
      pw_cnt_q <= '0;
      idx_q    <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      pw_cnt_q <= pw_cnt_d;
      idx_q    <= idx_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
    end
  end

  assign lcd_rw    = 1'b0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_quot_lcd_writer.sv
// Bench for quot_lcd_writer with short delays. Expected {rs,data} bytes are
// queued when stimulus is applied and popped on each rising lcd_e.
module tb_quot_lcd_writer;
  import divmod_lcd_pkg::*;

  localparam int E_P  = 2;
  localparam int CMDW = 4;
  localparam int CLRW = 8;
  localparam int PWR  = 10;
  localparam int SLOT = 1 + E_P + CMDW;
  localparam int INIT_LAT  = PWR + 3 * SLOT + (1 + E_P + CLRW);  // 42
  localparam int FRAME_LAT = 17 * SLOT;                          // 119

  logic       clk;
  logic       rst;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       start;
  logic       ready, done, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_data;
  logic [2:0] dbg_state;
  logic [1:0] dbg_phase;

  quot_lcd_writer #(
    .E_PULSE_CYC   (E_P),
    .CMD_WAIT_CYC  (CMDW),
    .CLR_WAIT_CYC  (CLRW),
    .PWRUP_WAIT_CYC(PWR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .quotient (quotient),
    .remainder(remainder),
    .start    (start),
    .ready    (ready),
    .done     (done),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_e    (lcd_e),
    .lcd_data (lcd_data),
    .dbg_state(dbg_state),
    .dbg_phase(dbg_phase)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  int         extra_cnt  = 0;
  int         bytes_seen = 0;
  int         done_cnt   = 0;
  int         e_width    = 0;
  logic       prev_e     = 1'b0;
  logic [8:0] rise_byte  = '0;
  logic [8:0] exp_byte;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (!rst && lcd_e && !prev_e) begin
      bytes_seen++;
      e_width   = 1;
      rise_byte = {lcd_rs, lcd_data};
      if (exp_q.size() == 0) begin
        extra_cnt++;
      end else begin
        exp_byte = exp_q.pop_front();
        check_eq("lcd_byte", {23'b0, lcd_rs, lcd_data}, {23'b0, exp_byte});
        check_eq("lcd_rw", {31'b0, lcd_rw}, 32'd0);
      end
    end else if (lcd_e && prev_e) begin
      e_width++;
    end else if (!lcd_e && prev_e && !rst) begin
      check_eq("e_width", e_width, E_P);
      check_eq("byte_hold", {23'b0, lcd_rs, lcd_data}, {23'b0, rise_byte});
    end
    prev_e = lcd_e;
  end

  // ---------------- driver tasks ----------------
  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
  endtask

  task automatic push_frame(input logic [7:0] q, input logic [3:0] r);
    string s;
    exp_q.push_back({1'b0, 8'h80});
    if (q == 8'hFF && r == 4'hF) s = "DIV BY ZERO     ";
    else s = $sformatf("Q=%02d.%04d R=%02d  ", q[7:4], q[3:0] * 625, r);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, s[i]});
  endtask

  task automatic release_and_init();
    int t0;
    int n;
    push_init();
    @(negedge clk);
    rst = 1'b0;
    t0  = cyc;
    n   = 0;
    while (ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_wait", {31'b0, ready}, 32'd1);
    check_eq("init_latency", cyc - t0, INIT_LAT);
    check_eq("init_drained", exp_q.size(), 0);
    check_eq("idle_state", {29'b0, dbg_state}, {29'b0, IDLE});
  endtask

  task automatic run_frame(input logic [7:0] q, input logic [3:0] r, input bit hold);
    int t0;
    int n;
    int d0;
    push_frame(q, r);
    d0        = done_cnt;
    quotient  = q;
    remainder = r;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    t0 = cyc;
    if (!hold) start = 1'b0;
    check_eq("ready_drop", {31'b0, ready}, 32'd0);
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
      if (n == 50) begin
        quotient  = 8'($urandom_range(0, 255));
        remainder = 4'($urandom_range(0, 15));
      end
    end
    check_eq("done_seen", {31'b0, done}, 32'd1);
    check_eq("frame_latency", cyc - t0, FRAME_LAT);
    start = 1'b0;
    @(negedge clk);
    check_eq("done_one_cycle", {31'b0, done}, 32'd0);
    check_eq("ready_back", {31'b0, ready}, 32'd1);
    repeat (20) @(negedge clk);
    check_eq("done_count", done_cnt - d0, 1);
    check_eq("frame_drained", exp_q.size(), 0);
    check_eq("extra_bytes", extra_cnt, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int b0;
    int d0;
    rst       = 1'b1;
    start     = 1'b0;
    quotient  = 8'h00;
    remainder = 4'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", {31'b0, ready}, 32'd0);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    check_eq("rst_e", {31'b0, lcd_e}, 32'd0);
    check_eq("rst_rs", {31'b0, lcd_rs}, 32'd0);
    check_eq("rst_rw", {31'b0, lcd_rw}, 32'd0);
    check_eq("rst_data", {24'b0, lcd_data}, 32'd0);
    check_eq("rst_state", {29'b0, dbg_state}, {29'b0, PWRUP});
    check_eq("rst_phase", {30'b0, dbg_phase}, {30'b0, W_IDLE});

    release_and_init();

    run_frame(8'h38, 4'h0, 1'b0);  // Q=03.5000 R=00
    run_frame(8'h35, 4'h1, 1'b0);  // Q=03.3125 R=01
    run_frame(8'hFF, 4'hF, 1'b0);  // divide by zero
    run_frame(8'hFF, 4'hE, 1'b0);  // not the sentinel pair
    run_frame(8'hAF, 4'h9, 1'b1);  // start held, inputs change mid-frame
    for (int k = 0; k < 3; k++)
      run_frame(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 1'b0);

    // Reset while TEXT byte 5 has e high.
    push_frame(8'h47, 4'h3);
    b0        = bytes_seen;
    quotient  = 8'h47;
    remainder = 4'h3;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!((bytes_seen - b0) == 7 && lcd_e === 1'b1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq("pre_rst_e", {31'b0, lcd_e}, 32'd1);
    d0 = done_cnt;
    #1 rst = 1'b1;
    #1;
    check_eq("async_e_drop", {31'b0, lcd_e}, 32'd0);
    check_eq("async_state", {29'b0, dbg_state}, {29'b0, PWRUP});
    exp_q.delete();
    repeat (3) @(negedge clk);
    release_and_init();
    check_eq("no_done_after_abort", done_cnt - d0, 0);
    run_frame(8'h12, 4'h7, 1'b0);

    check_eq("final_extra", extra_cnt, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/quot_lcd_writer.md
QUOT_LCD_WRITER -- requirements
Module: quot_lcd_writer

Interface
REQ-001 SHALL have parameter E_PULSE_CYC, default 25, LCD enable-high width in clocks.
REQ-002 SHALL have parameter CMD_WAIT_CYC, default 2500, post-byte wait in clocks for all bytes except clear.
REQ-003 SHALL have parameter CLR_WAIT_CYC, default 100000, post-byte wait in clocks after clear-display (0x01).
REQ-004 SHALL have parameter PWRUP_WAIT_CYC, default 1000000, idle delay in clocks after reset before the first init command.
REQ-005 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port quotient, input, 8, divider result in 4.4 unsigned fixed point.
REQ-008 SHALL have port remainder, input, 4, divider remainder.
REQ-009 SHALL have port start, input, 1, request to display the current quotient/remainder.
REQ-010 SHALL have port ready, output, 1, high only in IDLE; start is accepted only when high.
REQ-011 SHALL have port done, output, 1, one-cycle pulse when a frame write completes.
REQ-012 SHALL have ports lcd_rs, lcd_rw, lcd_e, each output, 1, HD44780 control lines; lcd_rw always 0.
REQ-013 SHALL have port lcd_data, output, 8, HD44780 8-bit data bus.

Function
REQ-014 Main FSM states SHALL be PWRUP, INIT, IDLE, ADDR, TEXT, DONE.
REQ-015 PWRUP SHALL count PWRUP_WAIT_CYC clocks, then enter INIT.
REQ-016 INIT SHALL send commands 0x38, 0x0C, 0x01, 0x06 in order with lcd_rs=0, then enter IDLE.
REQ-017 Each byte SHALL take 1 SETUP cycle with data/rs valid and e=0, then E_PULSE_CYC cycles with e=1, then a wait of CLR_WAIT_CYC cycles for byte 0x01 with rs=0, otherwise CMD_WAIT_CYC cycles, with e=0; data/rs held stable throughout.
REQ-018 In IDLE with start=1, quotient and remainder SHALL be captured at that edge, and ADDR SHALL be entered.
REQ-019 start SHALL be ignored whenever ready=0; later input changes SHALL not affect a frame in progress.
REQ-020 ADDR SHALL send 0x80 with rs=0.
REQ-021 TEXT SHALL send 16 ASCII bytes with rs=1, then enter DONE.
REQ-022 DONE SHALL assert done for one cycle and return to IDLE.
REQ-023 The normal frame SHALL be "Q=II.FFFF R=RR  ":
- II is quotient[7:4] as two decimal digits with a leading zero;
- FFFF is quotient[3:0]*625 as four decimal digits;
- RR is remainder as two decimal digits.
REQ-024 quotient=0xFF together with remainder=0xF SHALL be treated as divide-by-zero and SHALL display "DIV BY ZERO     " (this value pair cannot arise from a valid division).
REQ-025 Frame latency SHALL be exactly 17*(1+E_PULSE_CYC+CMD_WAIT_CYC) clocks from the start-accepting edge to the done pulse.
REQ-026 The wait counter SHALL be wide enough for max(PWRUP_WAIT_CYC, CLR_WAIT_CYC) with no wrap.

Reset
REQ-027 While rst=1, the block SHALL hold state PWRUP, all counters at 0, ready=0, done=0, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, and capture registers at 0.
REQ-028 rst asserted mid-frame or mid-init SHALL immediately drop lcd_e asynchronously, abandon the frame without a done pulse, and rerun the full PWRUP/INIT sequence after release.

Structure
REQ-029 Shared package divmod_lcd_pkg SHALL hold:
- the state encoding;
- the LCD command constants (0x38, 0x0C, 0x01, 0x06, 0x80);
- the 16-entry fraction-to-four-ASCII-digit table;
- the divide-by-zero sentinel values.
REQ-030 The SETUP/PULSE/WAIT byte sequencer SHALL be the sub-module lcd_byte_writer, with handshake go/busy/fin and a per-byte long_wait select.

Verification (E_PULSE_CYC=2, CMD_WAIT_CYC=4, CLR_WAIT_CYC=8, PWRUP_WAIT_CYC=10)
REQ-031 Release reset -> bytes 0x38,0x0C,0x01,0x06 appear with rs=0, and ready first reads 1 exactly 42 clocks after release.
REQ-032 quotient=0x38, remainder=0x0, start pulse -> 0x80, then "Q=03.5000 R=00  ", with done exactly 119 clocks after start.
REQ-033 quotient=0x35, remainder=0x1 -> "Q=03.3125 R=01  "; quotient=0xFF, remainder=0xF -> "DIV BY ZERO     ".
REQ-034 start held high through a frame while inputs change mid-frame -> exactly one frame, showing the captured values, and one done pulse.
REQ-035 rst pulsed during TEXT byte 5 with lcd_e=1 -> lcd_e=0 in the same cycle, no done pulse, and the init sequence is repeated.
